// File: rtl/line_doubler_pkg.sv
// rtl/line_doubler_pkg.sv - shared geometry defaults, underflow colour and FSM encoding for line_doubler
package line_doubler_pkg;

  localparam int SRC_W_DEF = 320;
  localparam int SRC_H_DEF = 240;
  localparam int PIX_W_DEF = 16;

  localparam logic [15:0] UNDERFLOW_COLOR = 16'hF800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/line_doubler_if.sv
// rtl/line_doubler_if.sv - FIFO, VTG and status signals of line_doubler grouped as one interface
interface line_doubler_if #(
  parameter int PIX_W = 16
) ();

  logic             i_frame_start;
  logic [PIX_W-1:0] i_fifo_data;
  logic             i_fifo_empty;
  logic             o_fifo_rd;
  logic             i_pix_req;
  logic [PIX_W-1:0] o_pix_data;
  logic             o_pix_valid;
  logic             o_underflow;
  logic [15:0]      o_underflow_cnt;
  logic [1:0]       o_state;

  modport master (
    output i_frame_start, i_fifo_data, i_fifo_empty, i_pix_req,
    input  o_fifo_rd, o_pix_data, o_pix_valid, o_underflow, o_underflow_cnt, o_state
  );

  modport slave (
    input  i_frame_start, i_fifo_data, i_fifo_empty, i_pix_req,
    output o_fifo_rd, o_pix_data, o_pix_valid, o_underflow, o_underflow_cnt, o_state
  );

endinterface

// File: rtl/line_buffer_2bank.sv
// rtl/line_buffer_2bank.sv - two-bank simple dual-port line RAM, one write port, one registered read port
module line_buffer_2bank #(
  parameter int AW    = 9,
  parameter int PIX_W = 16
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             wr_bank_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [PIX_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic             rd_bank_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [PIX_W-1:0] rd_data_o
);

  // Bank select is the address MSB, so each bank is a power-of-two region.
  logic [PIX_W-1:0] mem_q [0:(2**(AW+1))-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem_q[{rd_bank_i, rd_addr_i}];
    end
  end

endmodule

// File: rtl/line_doubler.sv
// rtl/line_doubler.sv - 2x2 upscaler from pixel FIFO to VTG; LINE_DOUBLER_STATS_EN enables underflow counter
module line_doubler
  import line_doubler_pkg::*;
#(
  parameter int SRC_W = SRC_W_DEF,
  parameter int SRC_H = SRC_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input logic          clk,
  input logic          rst,
  line_doubler_if.slave bus
);

  localparam int AW  = $clog2(SRC_W);
  localparam int FXW = $clog2(SRC_W + 1);
  localparam int LFW = $clog2(SRC_H + 1);
  localparam int OXW = $clog2(2 * SRC_W);
  localparam int OYW = $clog2(2 * SRC_H);

  localparam logic [FXW-1:0]   FX_END   = FXW'(SRC_W);
  localparam logic [LFW-1:0]   LF_END   = LFW'(SRC_H);
  localparam logic [AW-1:0]    WX_LAST  = AW'(SRC_W - 1);
  localparam logic [OXW-1:0]   OX_LAST  = OXW'(2 * SRC_W - 1);
  localparam logic [OYW-1:0]   OY_LAST  = OYW'(2 * SRC_H - 1);
  localparam logic [PIX_W-1:0] UF_COLOR = PIX_W'(UNDERFLOW_COLOR);

  state_e           state_q, state_d;
  logic [FXW-1:0]   fetch_x_q, fetch_x_d;
  logic [LFW-1:0]   lines_q, lines_d;
  logic [1:0]       ready_q, ready_d;
  logic             rd_pend_q, rd_pend_d;
  logic [AW-1:0]    wr_x_q, wr_x_d;
  logic             wr_bank_q, wr_bank_d;
  logic [OXW-1:0]   out_x_q, out_x_d;
  logic [OYW-1:0]   out_y_q, out_y_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             uf_sel_q, uf_sel_d;
  logic             uf_q, uf_d;

  logic             fetch_bank, fifo_rd, we, out_bank, serve, active, hit, uf_evt;
  logic [PIX_W-1:0] rd_data;

  always_comb begin
    state_d   = state_q;
    fetch_x_d = fetch_x_q;
    lines_d   = lines_q;
    ready_d   = ready_q;
    wr_x_d    = wr_x_q;
    wr_bank_d = wr_bank_q;
    out_x_d   = out_x_q;
    out_y_d   = out_y_q;
    done_d    = done_q;
    uf_d      = uf_q;

    // Fetch engine: one read per cycle into the bank of the next source line.
    fetch_bank = lines_q[0];
    fifo_rd    = (state_q == ST_PRIME || state_q == ST_RUN) && !bus.i_frame_start &&
                 !bus.i_fifo_empty && !ready_q[fetch_bank] &&
                 (fetch_x_q < FX_END) && (lines_q < LF_END);
    we         = rd_pend_q && !bus.i_frame_start;
    rd_pend_d  = fifo_rd;
    if (fifo_rd) begin
      wr_x_d    = fetch_x_q[AW-1:0];
      wr_bank_d = fetch_bank;
      fetch_x_d = fetch_x_q + FXW'(1);
    end
    if (we && wr_x_q == WX_LAST) begin
      ready_d[wr_bank_q] = 1'b1;
      lines_d            = lines_q + LFW'(1);
      fetch_x_d          = '0;
    end

    // Output engine: each source pixel twice per line, each source line on two output lines.
    out_bank = out_y_q[1];
    serve    = bus.i_pix_req && !bus.i_frame_start;
    active   = (state_q != ST_IDLE) && !done_q;
    hit      = serve && active && ready_q[out_bank];
    uf_evt   = serve && active && !ready_q[out_bank];
    valid_d  = serve;
    uf_sel_d = !hit;
    if (uf_evt) begin
      uf_d = 1'b1;
    end
    if (serve && active) begin
      if (out_x_q == OX_LAST) begin
        out_x_d = '0;
        out_y_d = out_y_q + OYW'(1);
        if (out_y_q[0]) begin
          ready_d[out_bank] = 1'b0;
        end
        if (out_y_q == OY_LAST) begin
          out_y_d = '0;
          done_d  = 1'b1;
        end
      end else begin
        out_x_d = out_x_q + OXW'(1);
      end
    end

    case (state_q)
      ST_PRIME: if (ready_q[0]) state_d = ST_RUN;
      ST_RUN:   if (lines_q == LF_END) state_d = ST_DRAIN;
      default:  state_d = state_q;
    endcase

    if (bus.i_frame_start) begin
      state_d   = ST_PRIME;
      fetch_x_d = '0;
      lines_d   = '0;
      ready_d   = '0;
      rd_pend_d = 1'b0;
      out_x_d   = '0;
      out_y_d   = '0;
      done_d    = 1'b0;
      uf_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fetch_x_q <= '0;
      lines_q   <= '0;
      ready_q   <= '0;
      rd_pend_q <= 1'b0;
      wr_x_q    <= '0;
      wr_bank_q <= 1'b0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      uf_sel_q  <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetch_x_q <= fetch_x_d;
      lines_q   <= lines_d;
      ready_q   <= ready_d;
      rd_pend_q <= rd_pend_d;
      wr_x_q    <= wr_x_d;
      wr_bank_q <= wr_bank_d;
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      uf_sel_q  <= uf_sel_d;
      uf_q      <= uf_d;
    end
  end

  line_buffer_2bank #(
    .AW    (AW),
    .PIX_W (PIX_W)
  ) u_buf (
    .clk       (clk),
    .we_i      (we),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_x_q),
    .wr_data_i (bus.i_fifo_data),
    .rd_en_i   (hit),
    .rd_bank_i (out_bank),
    .rd_addr_i (out_x_q[OXW-1:1]),
    .rd_data_o (rd_data)
  );

`ifdef LINE_DOUBLER_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (uf_evt && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst || bus.i_frame_start) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.o_underflow_cnt = cnt_q;
`else
  assign bus.o_underflow_cnt = 16'h0000;
`endif

  assign bus.o_fifo_rd   = fifo_rd;
  assign bus.o_pix_valid = valid_q;
  assign bus.o_pix_data  = valid_q ? (uf_sel_q ? UF_COLOR : rd_data) : '0;
  assign bus.o_underflow = uf_q;
  assign bus.o_state     = state_q;

endmodule

// File: tb/tb_line_doubler.sv
// tb/tb_line_doubler.sv - directed self-checking bench for line_doubler (320-pixel lines, 6-line frames)
module tb_line_doubler;
  import line_doubler_pkg::*;

  localparam int W  = 320;
  localparam int H  = 6;
  localparam int PW = 16;
`ifdef LINE_DOUBLER_STATS_EN
  localparam int UF_LINE = 640;
  localparam int UF_FOUR = 4;
`else
  localparam int UF_LINE = 0;
  localparam int UF_FOUR = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  line_doubler_if #(.PIX_W(PW)) bus ();

  line_doubler #(
    .SRC_W (W),
    .SRC_H (H),
    .PIX_W (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [PW-1:0] fifo_mem [0:4095];
  int push_n = 0;
  int pop_n = 0;
  int rd_empty_n = 0;
  logic [PW-1:0] exp_src [0:W-1];
  int n_cmp = 0;
  int n_bad = 0;
  int base;

  assign bus.i_fifo_empty = (push_n == pop_n);

  always @(posedge clk) begin
    if (bus.o_fifo_rd) begin
      if (push_n == pop_n) rd_empty_n <= rd_empty_n + 1;
      bus.i_fifo_data <= fifo_mem[pop_n[11:0]];
      pop_n <= pop_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [PW-1:0] v);
    fifo_mem[push_n[11:0]] = v;
    push_n++;
  endtask

  task automatic pulse_frame_start();
    @(negedge clk);
    bus.i_frame_start = 1'b1;
    @(negedge clk);
    bus.i_frame_start = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s);
    int n = 0;
    while (bus.o_state !== s && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.o_state), 32'(s));
  endtask

  // One full output line; each response is sampled on the negedge after its request edge.
  task automatic play_line(input string tag, input bit uf);
    logic [PW-1:0] e;
    for (int i = 0; i <= 2 * W; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = uf ? UNDERFLOW_COLOR : exp_src[(i - 1) / 2];
        check($sformatf("%s_valid[%0d]", tag, i - 1), 32'(bus.o_pix_valid), 32'd1);
        check($sformatf("%s[%0d]", tag, i - 1), 32'(bus.o_pix_data), 32'(e));
      end
      bus.i_pix_req = (i < 2 * W);
    end
    @(negedge clk);
    check({tag, "_idle"}, 32'(bus.o_pix_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_frame_start = 1'b0;
    bus.i_pix_req = 1'b0;
    for (int i = 0; i < W; i++) push(PW'(i));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    check("rst_state", 32'(bus.o_state), 32'd0);
    check("rst_fifo_rd", 32'(bus.o_fifo_rd), 32'd0);
    check("rst_pix_data", 32'(bus.o_pix_data), 32'd0);
    check("rst_pix_valid", 32'(bus.o_pix_valid), 32'd0);
    check("rst_underflow", 32'(bus.o_underflow), 32'd0);
    check("rst_uf_cnt", 32'(bus.o_underflow_cnt), 32'd0);
    check("idle_no_reads", 32'(pop_n), 32'd0);

    // Frame 1: ramp line, then FIFO starved for the second source line.
    pulse_frame_start();
    wait_state("f1_run", 2'd2);
    check("f1_reads", 32'(pop_n), 32'd320);
    for (int i = 0; i < W; i++) exp_src[i] = PW'(i);
    play_line("f1_y0", 1'b0);
    play_line("f1_y1", 1'b0);
    check("f1_no_uf", 32'(bus.o_underflow), 32'd0);
    play_line("f1_y2_uf", 1'b1);
    check("f1_uf_flag", 32'(bus.o_underflow), 32'd1);
    check("f1_uf_cnt", 32'(bus.o_underflow_cnt), 32'(UF_LINE));

    // Frame 2: full frame, source line k filled with k.
    pulse_frame_start();
    for (int k = 0; k < H; k++)
      for (int x = 0; x < W; x++) push(PW'(k));
    wait_state("f2_run", 2'd2);
    for (int y = 0; y < 2 * H; y++) begin
      for (int x = 0; x < W; x++) exp_src[x] = PW'(y / 2);
      play_line($sformatf("f2_y%0d", y), 1'b0);
    end
    check("f2_no_uf", 32'(bus.o_underflow), 32'd0);
    check("f2_uf_cnt", 32'(bus.o_underflow_cnt), 32'd0);
    check("f2_drain", 32'(bus.o_state), 32'd3);
    check("f2_reads", 32'(pop_n), 32'(W + H * W));
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) check($sformatf("f2_post[%0d]", i - 1), 32'(bus.o_pix_data), 32'(UNDERFLOW_COLOR));
      bus.i_pix_req = (i < 4);
    end
    check("f2_post_cnt", 32'(bus.o_underflow_cnt), 32'd0);

    // Frame 3: underflow, then frame_start with a request while a read is in flight.
    pulse_frame_start();
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      bus.i_pix_req = (i < 4);
    end
    check("f3_uf_flag", 32'(bus.o_underflow), 32'd1);
    check("f3_uf_cnt", 32'(bus.o_underflow_cnt), 32'(UF_FOUR));
    base = push_n;
    @(negedge clk);
    for (int i = 0; i < 5; i++) push(PW'(16'hA000 + i));
    repeat (3) @(negedge clk);
    bus.i_frame_start = 1'b1;
    bus.i_pix_req = 1'b1;
    @(negedge clk);
    bus.i_frame_start = 1'b0;
    bus.i_pix_req = 1'b0;
    check("f3_fs_no_valid", 32'(bus.o_pix_valid), 32'd0);
    check("f3_fs_uf_clr", 32'(bus.o_underflow), 32'd0);
    check("f3_fs_cnt_clr", 32'(bus.o_underflow_cnt), 32'd0);
    check("f3_fs_state", 32'(bus.o_state), 32'd1);
    check("f3_fs_reads", 32'(pop_n - base), 32'd3);
    for (int i = 0; i < W - 2; i++) push(PW'(16'hB000 + i));
    wait_state("f3_run", 2'd2);
    check("f3_reads", 32'(pop_n - base), 32'(W + 3));
    exp_src[0] = 16'hA003;
    exp_src[1] = 16'hA004;
    for (int x = 2; x < W; x++) exp_src[x] = PW'(16'hB000 + x - 2);
    play_line("f3_y0", 1'b0);
    check("rd_while_empty", 32'(rd_empty_n), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
